// File: rtl/sevseg_scroll_ctrl.sv
// Scrolling controller for the 4-digit seven-segment multiplexer: buffers decoded
// digit codes in a small FIFO and shifts one into the rightmost digit per scroll period.
module sevseg_scroll_ctrl #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter logic [3:0]  CLEAR_CODE = 4'd10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [3:0]               in_digit,
  output logic                     in_ready,
  input  logic                     clear,
  input  logic                     hold,
  output logic [3:0]               dig0,
  output logic [3:0]               dig1,
  output logic [3:0]               dig2,
  output logic [3:0]               dig3,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(TICK_DIV);

  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t          state;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [TW-1:0]   tick_cnt;
  logic [3:0]      mem [DEPTH];

  logic            push;
  logic            pop;
  logic [CW-1:0]   count_nxt;
  logic [3:0]      head;

  // Ready looks only at the registered count so a same-cycle pop never frees a full FIFO.
  assign in_ready  = rst_n & ~clear & (fifo_count != FULL_CNT);
  assign push      = in_valid & in_ready;
  assign pop       = (state == SHIFT);
  assign count_nxt = fifo_count + CW'(push) - CW'(pop);
  assign head      = mem[rd_ptr];

  // FIFO storage; push is already blocked during reset and clear.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_digit;
    end
  end

  // Scroll FSM, FIFO pointers/count and the display registers.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      busy       <= 1'b0;
      dig0       <= CLEAR_CODE;
      dig1       <= CLEAR_CODE;
      dig2       <= CLEAR_CODE;
      dig3       <= CLEAR_CODE;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      fifo_count <= count_nxt;
      busy       <= 1'b1;

      case (state)
        IDLE: begin
          tick_cnt <= '0;
          if ((fifo_count != '0) && !hold) begin
            state <= SHIFT;
          end else begin
            state <= IDLE;
            busy  <= (count_nxt != '0);
          end
        end

        SHIFT: begin
          rd_ptr   <= rd_ptr + PW'(1);
          dig3     <= dig2;
          dig2     <= dig1;
          dig1     <= dig0;
          dig0     <= head;
          tick_cnt <= '0;
          state    <= WAIT;
        end

        WAIT: begin
          // The period boundary sees a code pushed in this same cycle.
          if (!hold) begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              if (count_nxt != '0) begin
                state <= SHIFT;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end

        default: begin
          state    <= IDLE;
          tick_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sevseg_scroll_ctrl.sv
// Directed bench for sevseg_scroll_ctrl: a scoreboard queue of accepted codes is checked
// against every observed display shift, plus directed timing and flush checks.
module tb_sevseg_scroll_ctrl;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned TICK_DIV = 4;
  localparam logic [3:0]  DASH     = 4'd10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  in_digit;
  logic        in_ready;
  logic        clear;
  logic        hold;
  logic [3:0]  dig0, dig1, dig2, dig3;
  logic [2:0]  fifo_count;
  logic        busy;
  logic [15:0] disp;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int          shift_cnt = 0;
  int unsigned shift_cyc[$];
  logic [3:0]  exp_q[$];
  logic [15:0] prev_disp = 16'hAAAA;

  sevseg_scroll_ctrl #(
    .DEPTH(DEPTH),
    .TICK_DIV(TICK_DIV),
    .CLEAR_CODE(DASH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_digit(in_digit),
    .in_ready(in_ready),
    .clear(clear),
    .hold(hold),
    .dig0(dig0),
    .dig1(dig1),
    .dig2(dig2),
    .dig3(dig3),
    .fifo_count(fifo_count),
    .busy(busy)
  );

  assign disp = {dig3, dig2, dig1, dig0};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int n = 0;
    while (busy !== 1'b0 && n < max_cyc) begin
      step();
      n++;
    end
    check(tag, 32'(busy), 32'(0));
  endtask

  // Scoreboard push on accepted handshakes; flush on reset/clear edges.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n || clear) exp_q.delete();
    else if (in_valid && in_ready) exp_q.push_back(in_digit);
  end

  // Display monitor: any non-dash change is a shift and pops the scoreboard.
  always @(negedge clk) begin
    if (rst_n && (disp !== prev_disp)) begin
      if (disp !== 16'hAAAA) begin
        logic [3:0] e;
        shift_cnt++;
        shift_cyc.push_back(cyc);
        check("shift_move", 32'(disp[15:4]), 32'(prev_disp[11:0]));
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb_dig0", 32'(dig0), 32'(e));
        end
      end
      prev_disp = disp;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int n;
    rst_n = 1'b0; in_valid = 1'b0; in_digit = 4'd0; clear = 1'b0; hold = 1'b0;

    // Reset for three edges
    step();
    check("rst_in_ready", 32'(in_ready), 32'(0));
    check("rst_disp", 32'(disp), 32'h0000AAAA);
    check("rst_count", 32'(fifo_count), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    steps(2);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'(1));

    // Burst 1,2,3 on E0..E2
    in_valid = 1'b1; in_digit = 4'd1; step();
    in_digit = 4'd2; step();
    in_digit = 4'd3; step();
    in_valid = 1'b0;
    check("burst_e2_dig0", 32'(dig0), 32'(1));
    check("burst_e2_count", 32'(fifo_count), 32'(2));
    steps(3);
    check("burst_e5_dig0", 32'(dig0), 32'(1));
    step();
    check("burst_e6_dig10", 32'({dig1, dig0}), 32'h12);
    steps(4);
    check("burst_e10_disp", 32'(disp), 32'h0000A123);
    steps(4);
    check("burst_e14_busy", 32'(busy), 32'(0));
    check("burst_e14_count", 32'(fifo_count), 32'(0));

    // Backpressure with hold: 5..8 fill the FIFO, 9 is refused
    hold = 1'b1; in_valid = 1'b1;
    for (int c = 5; c <= 8; c++) begin
      in_digit = 4'(c);
      step();
    end
    in_digit = 4'd9;
    check("full_in_ready", 32'(in_ready), 32'(0));
    check("full_count", 32'(fifo_count), 32'(4));
    check("full_busy", 32'(busy), 32'(1));
    steps(2);
    check("full_count_stays", 32'(fifo_count), 32'(4));
    in_valid = 1'b0; hold = 1'b0;
    step();
    check("full_pop_in_ready", 32'(in_ready), 32'(0));
    step();
    check("full_after_pop_count", 32'(fifo_count), 32'(3));
    check("full_after_pop_ready", 32'(in_ready), 32'(1));
    check("full_first_dig0", 32'(dig0), 32'(5));
    wait_idle("full_idle", 60);
    check("full_final_disp", 32'(disp), 32'h00005678);
    check("full_sb_drained", 32'(exp_q.size()), 32'(0));

    // Pointer wrap: six spaced codes 0..5
    base = shift_cnt;
    for (int i = 0; i < 6; i++) begin
      n = 0;
      while (in_ready !== 1'b1 && n < 20) begin
        step();
        n++;
      end
      check("wrap_ready", 32'(in_ready), 32'(1));
      in_valid = 1'b1; in_digit = 4'(i);
      step();
      in_valid = 1'b0;
      steps(2);
    end
    wait_idle("wrap_idle", 80);
    check("wrap_shifts", 32'(shift_cnt - base), 32'(6));
    check("wrap_disp", 32'(disp), 32'h00002345);
    check("wrap_sb_drained", 32'(exp_q.size()), 32'(0));

    // Hold for 10 cycles in the WAIT after the first shift
    base = shift_cnt;
    in_valid = 1'b1; in_digit = 4'd7; step();
    in_digit = 4'd8; step();
    in_valid = 1'b0; step();
    check("hold_first_dig0", 32'(dig0), 32'(7));
    hold = 1'b1;
    steps(10);
    hold = 1'b0;
    n = 0;
    while (shift_cnt < base + 2 && n < 30) begin
      step();
      n++;
    end
    check("hold_shift_seen", 32'(shift_cnt - base), 32'(2));
    check("hold_gap", shift_cyc[$] - shift_cyc[$-1], 32'(14));
    check("hold_second_dig0", 32'(dig0), 32'(8));
    wait_idle("hold_idle", 40);

    // Clear with two codes pending
    in_valid = 1'b1; in_digit = 4'd1; step();
    in_digit = 4'd2; step();
    in_digit = 4'd3; step();
    in_valid = 1'b0;
    check("clr_pending", 32'(fifo_count), 32'(2));
    clear = 1'b1;
    #1;
    check("clr_in_ready", 32'(in_ready), 32'(0));
    step();
    clear = 1'b0;
    check("clr_disp", 32'(disp), 32'h0000AAAA);
    check("clr_count", 32'(fifo_count), 32'(0));
    check("clr_busy", 32'(busy), 32'(0));
    base = shift_cnt;
    steps(12);
    check("clr_no_shift", 32'(shift_cnt - base), 32'(0));
    check("clr_disp_stays", 32'(disp), 32'h0000AAAA);

    // Same scenario flushed by a one-cycle reset
    in_valid = 1'b1; in_digit = 4'd1; step();
    in_digit = 4'd2; step();
    in_digit = 4'd3; step();
    in_valid = 1'b0;
    check("rst2_first_disp", 32'(disp), 32'h0000AAA1);
    check("rst2_pending", 32'(fifo_count), 32'(2));
    rst_n = 1'b0;
    #1;
    check("rst2_in_ready_low", 32'(in_ready), 32'(0));
    step();
    rst_n = 1'b1;
    #1;
    check("rst2_disp", 32'(disp), 32'h0000AAAA);
    check("rst2_count", 32'(fifo_count), 32'(0));
    check("rst2_busy", 32'(busy), 32'(0));
    check("rst2_in_ready", 32'(in_ready), 32'(1));
    base = shift_cnt;
    steps(12);
    check("rst2_no_shift", 32'(shift_cnt - base), 32'(0));
    check("rst2_disp_stays", 32'(disp), 32'h0000AAAA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sevseg_scroll_ctrl.md
# sevseg_scroll_ctrl

Scrolling controller for the 4-digit seven-segment multiplexer. It accepts decoded digit codes from the Morse decoder over a valid/ready handshake and buffers them in a small FIFO. One buffered code is shifted into the rightmost digit per scroll period, and the older digits move one place left. The outputs drive the multiplexer's four digit-value inputs directly: dig0 is the rightmost digit (anode 0) and dig3 the leftmost (anode 3).

## Interface
- DEPTH, 8: FIFO depth in entries; power of two, ≥2.
- TICK_DIV, 50_000_000: clock cycles per scroll step while data is pending; ≥2.
- CLEAR_CODE, 4'd10: code loaded into all digits on reset/clear (renders as dash).
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  producer has a digit code.
- in_digit  in  4  digit code; 0–9 are digits, 10–15 render as dash.
- in_ready  out  1  FIFO can accept this cycle.
- clear  in  1  synchronous flush of FIFO and display.
- hold  in  1  freeze scrolling; FIFO still accepts.
- dig0, dig1, dig2, dig3  out  4 each  registered display codes, right to left.
- fifo_count  out  $clog2(DEPTH)+1  registered FIFO occupancy.
- busy  out  1  high when state ≠ IDLE or fifo_count ≠ 0.

## Operation
- Transfer: a code is accepted on a clock edge when in_valid & in_ready. in_ready = rst_n & ~clear & (fifo_count != DEPTH), combinational from registered count only.
- Full FIFO: in_ready=0 even if a pop occurs in the same cycle. Not full with push+pop in the same cycle: count unchanged, both take effect.
- FIFO pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Count saturates at neither end because the handshake prevents over/underflow.
- FSM states: IDLE, SHIFT, WAIT.
  - IDLE: tick counter = 0. Go to SHIFT when fifo_count ≠ 0 and hold=0; otherwise stay.
  - SHIFT: lasts exactly one cycle. Pop the FIFO head; dig3←dig2, dig2←dig1, dig1←dig0, dig0←head. Load tick counter with 0. Go to WAIT.
  - WAIT: tick counter increments each cycle while hold=0 and is frozen while hold=1. At counter = TICK_DIV−2 with hold=0: go to SHIFT if fifo_count ≠ 0 (count after any same-cycle push), else IDLE.
- Tick counter width: $clog2(TICK_DIV).
- clear=1 (priority below reset, above all else):
  - Next edge sets dig0..dig3=CLEAR_CODE, FIFO pointers and count = 0, state=IDLE, counter=0.
  - Input presented during the clear cycle is dropped.
  - A SHIFT coinciding with clear is discarded.
- Reset (rst_n=0 at an edge): same effect as clear. in_ready=0 while rst_n=0.
- Reset values: dig0..dig3=CLEAR_CODE, fifo_count=0, busy=0, in_ready=0 during reset, 1 after release.

## Timing
- First-digit latency from IDLE: code accepted at edge E0; FSM enters SHIFT at E1; dig0 shows the code after E2.
- Steady scroll: with the FIFO non-empty and hold=0, consecutive SHIFT cycles are exactly TICK_DIV cycles apart.
- After the last pop, at least TICK_DIV cycles elapse (through WAIT) before returning to IDLE. A code arriving during that WAIT shifts at the normal period boundary, not early.
- Hold: hold=1 for H cycles during WAIT delays the next SHIFT by exactly H cycles. Hold asserted in SHIFT does not cancel that SHIFT.
- Outputs dig*, fifo_count, and busy are registered with no combinational path from inputs. in_ready depends combinationally on rst_n and clear only.

## Test plan
Bench parameters: TICK_DIV=4, DEPTH=4.
- Reset: hold rst_n=0 for 3 cycles, then release -> dig3..dig0=A,A,A,A; fifo_count=0; busy=0; in_ready=0 during reset, 1 in the first cycle after release.
- Burst: push 1,2,3 on consecutive edges E0–E2 -> dig0=1 after E2; dig1,dig0=1,2 after E6; dig3..dig0=A,1,2,3 after E10; FSM back in IDLE with busy=0 after E14.
- Full/backpressure: hold=1, offer 5,6,7,8,9 every cycle -> first four accepted, in_ready=0 while 9 is presented, fifo_count=4. Release hold -> display ends at 5,6,7,8 with 9 never shown unless re-offered.
- Pointer wrap: push 6 codes (0–5) spaced so the FIFO never fills -> displayed sequence is exactly 0..5 in order; the last four shown are 2,3,4,5.
- Hold mid-WAIT: during the 4-cycle period after the first shift, assert hold for 10 cycles -> second shift occurs 14 cycles after the first instead of 4.
- Clear and mid-operation reset: with 2 codes pending, pulse clear during WAIT -> next edge dig=A,A,A,A, fifo_count=0, busy=0, no further shifts. Repeat using rst_n=0 for 1 cycle -> identical result.
